imem_loader: RTL and testbench

Byte-stream program loader that sits beside `riscv_cpu` and writes its instruction memory. It accepts a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues one write per word to the instruction-memory write port. It holds the CPU in reset for the whole load and releases it only after the final word has been written.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream ingress plus instruction-memory write port of the program loader.
// Loader side uses the slave modport; the stream source / memory model uses master.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed little-endian byte stream -> 32-bit instruction-memory writes; holds the CPU in reset until loaded.
// Latency: im_we one cycle after the 4th byte of a word. Backpressure: byte_ready low outside a load and in the im_we cycle.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    input  logic              load_req,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam state_t      END_ST = CHK_EN ? S_CHK : S_DONE;
    localparam logic [16:0] CAP    = 17'(1) << ADDR_W;

    state_t            state;
    logic [7:0]        n_lo;
    logic [15:0]       n_words;
    logic [1:0]        byte_idx;
    logic [23:0]       lanes;
    logic [7:0]        chk_acc;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [31:0]       im_wdata_q;
    logic              xfer;
    logic [15:0]       n_hdr;

    assign busy    = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA) || (state == S_CHK);
    assign done    = (state == S_DONE);
    assign err     = (state == S_ERR);
    assign cpu_rst = (state != S_DONE);

    assign bus.byte_ready = busy & ~im_we_q;
    assign bus.im_we      = im_we_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = im_wdata_q;

    assign xfer  = bus.byte_valid & bus.byte_ready;
    assign n_hdr = {bus.byte_in, n_lo};

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_lo       <= '0;
            n_words    <= '0;
            byte_idx   <= '0;
            lanes      <= '0;
            chk_acc    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            word_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_req) begin
                        state    <= S_HDR0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        chk_acc  <= '0;
                    end
                end
                S_HDR0: begin
                    if (xfer) begin
                        n_lo  <= bus.byte_in;
                        state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        n_words <= n_hdr;
                        if ({1'b0, n_hdr} > CAP)
                            state <= S_ERR;
                        else if (n_hdr == 16'd0)
                            state <= END_ST;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    // word_cnt already counts the word being written, so it equals N on the last one
                    if (im_we_q) begin
                        im_we_q <= 1'b0;
                        if (16'(word_cnt) == n_words)
                            state <= END_ST;
                    end else if (xfer) begin
                        chk_acc  <= chk_acc ^ bus.byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: lanes[7:0]   <= bus.byte_in;
                            2'd1: lanes[15:8]  <= bus.byte_in;
                            2'd2: lanes[23:16] <= bus.byte_in;
                            default: begin
                                im_wdata_q <= {bus.byte_in, lanes};
                                im_addr_q  <= word_cnt[ADDR_W-1:0];
                                im_we_q    <= 1'b1;
                                word_cnt   <= word_cnt + 1'b1;
                            end
                        endcase
                    end
                end
                S_CHK: begin
                    if (xfer)
                        state <= (bus.byte_in == chk_acc) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected writes, one task per scenario.
module tb_imem_loader;
    localparam int ADDR_W = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk_100MHz = 1'b0;
    logic              rst_n      = 1'b0;
    logic              load_req   = 1'b0;
    logic              cpu_rst, busy, done, err;
    logic [ADDR_W:0]   word_cnt;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .bus        (bus),
        .load_req   (load_req),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int vectors     = 0;
    int miscompares = 0;
    int n_writes    = 0;
    int edges       = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        words[$];

    // Scoreboard: every im_we pulse is popped against the queue
    always @(negedge clk_100MHz) begin
        if (bus.im_we === 1'b1) begin
            logic [ADDR_W+31:0] e;
            n_writes++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%h data=%h", bus.im_addr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.im_addr, bus.im_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             bus.im_addr, bus.im_wdata, e[ADDR_W+31:32], e[31:0]);
                end
            end
            vectors++;
            if ({bus.byte_ready, cpu_rst} !== 2'b01) begin
                miscompares++;
                $display("FAIL ready_cpu_rst_during_we got ready=%b cpu_rst=%b want ready=0 cpu_rst=1",
                         bus.byte_ready, cpu_rst);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        bus.byte_valid = 1'b0;
        repeat (gap) @(posedge clk_100MHz);
        if (gap > 0) #1;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            r = bus.byte_ready;
            @(posedge clk_100MHz);
            #1;
            edges++;
            if (r) begin
                bus.byte_valid = 1'b0;
                return;
            end
        end
        bus.byte_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL byte_accept_timeout byte=%h got ready=0 want ready=1", b);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(posedge clk_100MHz);
        #1;
        load_req = 1'b0;
        vectors++;
        if ({busy, word_cnt} !== {1'b1, {(ADDR_W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL start_load got busy=%b word_cnt=%0d want busy=1 word_cnt=0", busy, word_cnt);
        end
    endtask

    // Sends header, words[] payload and (if enabled) checksum; pushes expected writes
    task automatic run_load(input int n, input int max_gap, input bit corrupt);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [31:0] w;
        logic [15:0] n16;
        x   = 8'h00;
        n16 = 16'(n);
        bytes.push_back(n16[7:0]);
        bytes.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                bytes.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
            exp_q.push_back({ADDR_W'(i), w});
        end
        if (CHK_EN) bytes.push_back(corrupt ? 8'hFF : x);
        edges = 0;
        foreach (bytes[k])
            send_byte(bytes[k], (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap)));
    endtask

    task automatic wait_end();
        for (int t = 0; t < 100; t++) begin
            if (done || err) return;
            @(posedge clk_100MHz);
            #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL end_timeout got done=0 err=0 want done|err=1");
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({busy, done, err, cpu_rst, bus.byte_ready, bus.im_we} !== 6'b000100) begin
            miscompares++;
            $display("FAIL %s_flags got busy=%b done=%b err=%b cpu_rst=%b ready=%b we=%b want 0 0 0 1 0 0",
                     tag, busy, done, err, cpu_rst, bus.byte_ready, bus.im_we);
        end
        vectors++;
        if ({bus.im_addr, bus.im_wdata, word_cnt} !== '0) begin
            miscompares++;
            $display("FAIL %s_regs got addr=%h data=%h word_cnt=%0d want all 0",
                     tag, bus.im_addr, bus.im_wdata, word_cnt);
        end
    endtask

    task automatic check_end(input string tag, input bit want_done, input int want_cnt, input int want_writes);
        vectors++;
        if ({done, err, cpu_rst, busy, bus.byte_ready} !== {want_done, ~want_done, ~want_done, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_state got done=%b err=%b cpu_rst=%b busy=%b ready=%b want done=%b err=%b cpu_rst=%b busy=0 ready=0",
                     tag, done, err, cpu_rst, busy, bus.byte_ready, want_done, ~want_done, ~want_done);
        end
        vectors++;
        if (int'(word_cnt) !== want_cnt) begin
            miscompares++;
            $display("FAIL %s_word_cnt got %0d want %0d", tag, word_cnt, want_cnt);
        end
        vectors++;
        if (n_writes !== want_writes || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_writes got %0d pending=%0d want %0d pending=0",
                     tag, n_writes, exp_q.size(), want_writes);
        end
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk_100MHz);
        #1;
        check_reset_outputs("post_reset");
    endtask

    task automatic test_basic_load();
        int w0;
        w0 = n_writes;
        words = '{32'h00500013, 32'h00A00093};
        start_load();
        run_load(2, 0, 1'b0);
        vectors++;
        if (edges !== (CHK_EN ? 13 : 11)) begin
            miscompares++;
            $display("FAIL throughput_edges got %0d want %0d", edges, CHK_EN ? 13 : 11);
        end
        wait_end();
        check_end("basic", 1'b1, 2, w0 + 2);
    endtask

    task automatic test_zero_words();
        int w0;
        w0 = n_writes;
        words = {};
        start_load();
        run_load(0, 0, 1'b0);
        wait_end();
        check_end("zero", 1'b1, 0, w0);
    endtask

    task automatic test_overflow();
        int w0;
        w0 = n_writes;
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check_end("overflow", 1'b0, 0, w0);
        bus.byte_in    = 8'h5A;
        bus.byte_valid = 1'b1;
        repeat (3) @(posedge clk_100MHz);
        #1;
        bus.byte_valid = 1'b0;
        check_end("overflow_ignore", 1'b0, 0, w0);
    endtask

    task automatic test_random_gaps();
        int w0;
        w0 = n_writes;
        words = '{32'h00500013, 32'h00A00093};
        start_load();
        run_load(2, 3, 1'b0);
        wait_end();
        check_end("gaps", 1'b1, 2, w0 + 2);
    endtask

    task automatic test_reset_mid_load();
        int w0;
        logic [7:0] part[$];
        part = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
        start_load();
        exp_q.push_back({ADDR_W'(0), 32'h00500013});
        foreach (part[k]) send_byte(part[k], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) @(posedge clk_100MHz);
        #1;
        rst_n = 1'b1;
        @(posedge clk_100MHz);
        #1;
        w0 = n_writes;
        words = '{32'hDEADBEEF, 32'h12345678};
        start_load();
        run_load(2, 0, 1'b0);
        wait_end();
        check_end("reload", 1'b1, 2, w0 + 2);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int w0;
        w0 = n_writes;
        words = '{32'h00500013, 32'h00A00093};
        start_load();
        run_load(2, 0, 1'b1);
        wait_end();
        check_end("bad_chk", 1'b0, 2, w0 + 2);
        words = '{32'h00500013, 32'h00A00093};
        start_load();
        run_load(2, 0, 1'b0);
        wait_end();
        check_end("chk_retry", 1'b1, 2, w0 + 4);
    endtask
`else
    task automatic test_three_words();
        int w0;
        w0 = n_writes;
        words = '{32'hA5A5_0001, 32'h0000_FF00, 32'h8000_0000};
        start_load();
        run_load(3, 0, 1'b0);
        wait_end();
        check_end("three", 1'b1, 3, w0 + 3);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_zero_words();
        test_overflow();
        test_random_gaps();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`else
        test_three_words();
`endif
        repeat (2) @(posedge clk_100MHz);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
